// File: rtl/axi_8bit_pkg.sv
// Shared definitions for the 8-bit AXI-Stream link (receiver and transmitter blocks).
// Holds the data width, the stall-LFSR tap mask and default seed, and the LFSR step function.
package axi_8bit_pkg;

    localparam int DATA_W = 8;

    // Fibonacci taps 8,6,5,4 expressed as a mask over bits [7:0].
    localparam logic [DATA_W-1:0] LFSR_TAPS         = 8'hB8;
    localparam logic [DATA_W-1:0] LFSR_SEED_DEFAULT = 8'hA5;

    function automatic logic [DATA_W-1:0] lfsr_next(input logic [DATA_W-1:0] state);
        return {state[DATA_W-2:0], ^(state & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/axi_8bit_fifo_sync.sv
// First-word-fall-through synchronous FIFO with extra-MSB pointers; the head is
// presented combinationally from storage and reads as zero while empty.
module axi_8bit_fifo_sync
    import axi_8bit_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = DATA_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_data,
    input  logic             i_pop,
    output logic             o_full,
    output logic             o_empty,
    output logic [WIDTH-1:0] o_head
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic             w_do_push;
    logic             w_do_pop;

    assign o_empty   = (r_wr_ptr == r_rd_ptr);
    assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                       (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
        end
    end

    // NOTE: storage has no reset; stale entries are never visible because the
    // head is masked while empty, and leaving it unreset keeps it plain RAM.
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_push_data;
    end

    assign o_head = o_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];

endmodule

// File: rtl/axi_8bit_receiver_sync.sv
// AXI-Stream 8-bit sink: valid/ready handshake into an FWFT FIFO, pop interface out,
// wrapping accepted-byte counter. Define AXI_RX_THROTTLE_EN for the LFSR ready-stall generator.
module axi_8bit_receiver_sync
    import axi_8bit_pkg::*;
#(
    parameter int                DEPTH     = 4,
    parameter int                CNT_W     = 16,
    parameter logic [DATA_W-1:0] LFSR_SEED = LFSR_SEED_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              s_axis_valid,
    output logic              s_axis_ready,
    input  logic [DATA_W-1:0] s_axis_data,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ack,
    output logic [CNT_W-1:0]  rx_count
);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("DEPTH must be a power of two and at least 2");
    end
    if (LFSR_SEED == '0) begin : g_bad_seed
        $error("LFSR_SEED must be non-zero");
    end

    logic             w_full;
    logic             w_empty;
    logic             w_stall;
    logic             w_push;
    logic             w_pop;
    logic [CNT_W-1:0] r_rx_count;

`ifdef AXI_RX_THROTTLE_EN
    logic [DATA_W-1:0] r_lfsr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_lfsr <= LFSR_SEED;
        else        r_lfsr <= lfsr_next(r_lfsr);
    end

    assign w_stall = (r_lfsr[1:0] == 2'b00);
`else
    assign w_stall = 1'b0;
`endif

    // Ready comes only from registered state so it never loops back through s_axis_valid.
    assign s_axis_ready = !w_full && !w_stall;
    assign w_push       = s_axis_valid && s_axis_ready;
    assign out_valid    = !w_empty;
    assign w_pop        = out_valid && out_ack;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      r_rx_count <= '0;
        else if (w_push) r_rx_count <= r_rx_count + CNT_W'(1);
    end

    assign rx_count = r_rx_count;

    axi_8bit_fifo_sync #(
        .DEPTH (DEPTH),
        .WIDTH (DATA_W)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_push      (w_push),
        .i_push_data (s_axis_data),
        .i_pop       (w_pop),
        .o_full      (w_full),
        .o_empty     (w_empty),
        .o_head      (out_data)
    );

endmodule

// File: doc/axi_8bit_receiver_sync.md
# axi_8bit_receiver_sync

Synchronous AXI-Stream 8-bit slave (receiver): the sink end of the 8-bit stream link that feeds the adder datapath. It accepts bytes on a valid/ready handshake, buffers them in a small first-word-fall-through FIFO, and presents them to the downstream consumer on a pop interface. An optional LFSR-driven stall generator deasserts ready pseudo-randomly to exercise upstream backpressure.

## Interface
- DEPTH, 4, FIFO entries; power of two, minimum 2
- CNT_W, 16, width of the accepted-byte counter
- LFSR_SEED, 8'hA5, reset value of the stall LFSR; must be non-zero
- clk  in  1  single clock, rising edge
- rst_n  in  1  reset; asynchronous and active-low
- s_axis_valid  in  1  upstream data valid
- s_axis_ready  out  1  receiver can accept this cycle
- s_axis_data  in  8  upstream byte
- out_valid  out  1  FIFO head holds a byte
- out_data  out  8  FIFO head byte; valid only while out_valid=1
- out_ack  in  1  consumer pops head this cycle; ignored when out_valid=0
- rx_count  out  CNT_W  number of accepted bytes since reset, wrapping

## Operation
- Transfer occurs on a rising clk edge where s_axis_valid=1 and s_axis_ready=1; s_axis_data is written at the FIFO tail and rx_count increments by 1.
- s_axis_ready = !full, AND-ed with !stall when throttling is enabled. It depends only on registered state, never combinationally on s_axis_valid.
- Pop occurs on an edge where out_valid=1 and out_ack=1; the head advances.
- FIFO uses read/write pointers of log2(DEPTH)+1 bits. Full means the pointers differ only in the MSB. Empty means the pointers are equal. Pointers wrap modulo 2*DEPTH.
- Simultaneous push and pop with 0 < level < DEPTH: level is unchanged and both pointers advance.
- When empty, push and pop cannot both occur, because out_valid=0.
- When full, s_axis_ready=0, so no push is taken in the pop cycle. Ready rises on the edge after the pop.
- rx_count wraps from 2^CNT_W-1 to 0 without a flag.
- Upstream holding valid with ready low is legal. Data must stay stable until accepted; the receiver does not check this.
- rst_n assertion at any time, including mid-transfer, clears pointers, rx_count and the LFSR state immediately. Buffered data is discarded.

## Timing
- Reset values: s_axis_ready=1 (or the LFSR-derived value when throttling is enabled), out_valid=0, out_data=8'h00, rx_count=0.
- Latency: a byte accepted on edge N appears on out_data with out_valid=1 after edge N; the consumer can pop it on edge N+1.
- out_data always shows the current head combinationally from the FIFO storage. No extra output register.
- Throughput is 1 byte/cycle sustained when the consumer holds out_ack=1 and throttling is off.
- After rst_n deasserts, the first transfer can occur on the first rising edge.

## Configuration
- AXI_RX_THROTTLE_EN defined:
  - An 8-bit Fibonacci LFSR (taps 8,6,5,4), reset to LFSR_SEED, advances every cycle.
  - stall = (lfsr[1:0]==2'b00), giving roughly 25% forced ready-low cycles.
  - s_axis_ready = !full & !stall.
- AXI_RX_THROTTLE_EN undefined:
  - There is no LFSR logic.
  - s_axis_ready = !full.

## Structure
- Shared package axi_8bit_pkg:
  - DATA_W=8
  - LFSR tap constant
  - default LFSR_SEED
  - This package is shared with the transmitter blocks.
- Sub-module axi_8bit_fifo_sync: a parameterised FWFT FIFO (push, pop, full, empty, head). The top level contains the handshake, the counter and the throttle.

## Test plan
- Reset, throttle off:
  - Stimulus: drive rst_n=0 mid-stream.
  - Required response: out_valid=0, rx_count=0 and s_axis_ready=1 asynchronously, before the next edge.
- Single byte:
  - Stimulus: send 8'h3C with out_ack=0.
  - Required response: out_valid=1 and out_data=8'h3C one edge later; rx_count=1; ack pops it and out_valid returns to 0.
- Fill and overflow guard:
  - Stimulus: send 8'h01..8'h06 with out_ack=0 and DEPTH=4.
  - Required response: ready drops after 4 accepts; rx_count=4; bytes 05/06 are held off; popping one raises ready on the next edge and 8'h05 is accepted; output order is 01,02,03,04,05,06.
- Simultaneous push and pop at level 2:
  - Stimulus: push and pop on the same edge.
  - Required response: level stays 2; head advances correctly; no lost or duplicated byte.
- Streaming wrap:
  - Stimulus: 20 sequential bytes at full rate with out_ack=1.
  - Required response: 20 bytes out in order; pointers wrap; rx_count=20.
  - Additional case: with CNT_W=4, rx_count wraps to 4.
- AXI_RX_THROTTLE_EN:
  - Stimulus: continuous valid for 256 cycles.
  - Required response: ready-low cycles are exactly those with lfsr[1:0]==0, checked against a reference LFSR seeded with 8'hA5; all accepted data arrives in order.
